// File: rtl/sp_sram_be.sv
// Single-port synchronous SRAM with lane byte enables, a post-reset/on-request clear engine,
// selectable read-during-write result and an optional output pipeline register.
module sp_sram_be #(
  parameter int                    ADDR_WIDTH = 4,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    LANE_WIDTH = 8,
  parameter int                    DEPTH      = 2**ADDR_WIDTH,
  parameter int                    RDW_MODE   = 0,
  parameter int                    OUT_REG    = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                req,
  input  logic                                wr,
  input  logic [ADDR_WIDTH-1:0]               addr,
  input  logic [DATA_WIDTH-1:0]               din,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0]    be,
  input  logic                                clr,
  output logic                                busy,
  output logic                                qvalid,
  output logic [DATA_WIDTH-1:0]               qout,
  output logic                                dbg_state
);

  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {READY = 1'b0, CLEAR = 1'b1} state_e;

  // Handshake: an access is taken on a rising edge when busy=0, req=1 and clr=0;
  // its response appears as a one-cycle qvalid strobe 1+OUT_REG cycles later.
  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    in_range;
  logic                    accept;
  logic                    mem_we;
  logic [DATA_WIDTH-1:0]   old_word;
  logic [DATA_WIDTH-1:0]   merged_word;
  logic [DATA_WIDTH-1:0]   resp_word;

  logic                    vld1_q;
  logic [DATA_WIDTH-1:0]   dat1_q;

  assign busy      = (state_q == CLEAR);
  assign dbg_state = state_q;

  always_comb begin
    in_range    = ({1'b0, addr} < DEPTH_W);
    accept      = (state_q == READY) && req && !clr;
    mem_we      = accept && wr && in_range;
    old_word    = in_range ? mem_q[addr] : '0;
    merged_word = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (be[i]) merged_word[i*LANE_WIDTH +: LANE_WIDTH] = din[i*LANE_WIDTH +: LANE_WIDTH];
    end
    // Out-of-range accesses always answer zero, whatever the mode.
    if (!in_range)                  resp_word = '0;
    else if (wr && (RDW_MODE != 0)) resp_word = merged_word;
    else                            resp_word = old_word;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = READY;
          ptr_d   = '0;
        end
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // The array has no reset; the clear engine initialises it instead.
  always_ff @(posedge clk) begin
    if (state_q == CLEAR)  mem_q[ptr_q] <= CLEAR_VAL;
    else if (mem_we)       mem_q[addr]  <= merged_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_q <= 1'b0;
      dat1_q <= '0;
    end else begin
      vld1_q <= accept;
      if (accept) dat1_q <= resp_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  vld2_q;
      logic [DATA_WIDTH-1:0] dat2_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld2_q <= 1'b0;
          dat2_q <= '0;
        end else begin
          vld2_q <= vld1_q;
          if (vld1_q) dat2_q <= dat1_q;
        end
      end
      assign qvalid = vld2_q;
      assign qout   = dat2_q;
    end else begin : g_no_out_reg
      assign qvalid = vld1_q;
      assign qout   = dat1_q;
    end
  endgenerate

endmodule

// File: tb/tb_sp_sram_be.sv
// Bench for sp_sram_be: two instances (16 words/no output reg/old-data, 12 words/output reg/write-through)
// driven by shared directed stimulus and checked each cycle against a word-level model.
module tb_sp_sram_be;

  localparam logic [15:0] CV = 16'hA5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] din = '0;
  logic [1:0]  be = '0;
  logic        clr = 1'b0;

  logic        busy_a, qvalid_a, dbg_a;
  logic [15:0] qout_a;
  logic        busy_b, qvalid_b, dbg_b;
  logic [15:0] qout_b;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  sp_sram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .LANE_WIDTH(8), .DEPTH(16),
               .RDW_MODE(0), .OUT_REG(0), .CLEAR_VAL(CV)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .din(din), .be(be),
    .clr(clr), .busy(busy_a), .qvalid(qvalid_a), .qout(qout_a), .dbg_state(dbg_a));

  sp_sram_be #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .LANE_WIDTH(8), .DEPTH(12),
               .RDW_MODE(1), .OUT_REG(1), .CLEAR_VAL(CV)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .din(din), .be(be),
    .clr(clr), .busy(busy_b), .qvalid(qvalid_b), .qout(qout_b), .dbg_state(dbg_b));

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- word-level model ----------------
  typedef struct {int k; int due; logic [15:0] d;} resp_t;
  resp_t       pq[$];
  logic [15:0] mm [2][16];
  bit          clearing [2] = '{1'b1, 1'b1};
  int          cnt [2] = '{0, 0};
  bit          exp_qv [2] = '{1'b0, 1'b0};
  logic [15:0] exp_q [2] = '{16'h0, 16'h0};
  int          edge_n = 0;
  int          m_depth [2] = '{16, 12};
  int          m_lat [2] = '{1, 2};
  bit          m_rdw [2] = '{1'b0, 1'b1};

  task automatic model_step(input int k);
    logic [15:0] old, mer, rsp;
    bit          inr;
    if (!rst_n) begin
      clearing[k] = 1'b1;
      cnt[k] = 0;
      for (int j = pq.size() - 1; j >= 0; j--) if (pq[j].k == k) pq.delete(j);
      exp_qv[k] = 1'b0;
      exp_q[k] = 16'h0;
      return;
    end
    if (clearing[k]) begin
      mm[k][cnt[k]] = CV;
      cnt[k]++;
      if (cnt[k] == m_depth[k]) clearing[k] = 1'b0;
    end else if (clr) begin
      clearing[k] = 1'b1;
      cnt[k] = 0;
    end else if (req) begin
      inr = (int'(addr) < m_depth[k]);
      old = inr ? mm[k][addr] : 16'h0;
      mer = old;
      if (be[0]) mer[7:0]  = din[7:0];
      if (be[1]) mer[15:8] = din[15:8];
      if (wr && inr) mm[k][addr] = mer;
      rsp = !inr ? 16'h0 : ((wr && m_rdw[k]) ? mer : old);
      pq.push_back('{k, edge_n + m_lat[k] - 1, rsp});
    end
    exp_qv[k] = 1'b0;
    for (int j = pq.size() - 1; j >= 0; j--) begin
      if (pq[j].k == k && pq[j].due == edge_n) begin
        exp_qv[k] = 1'b1;
        exp_q[k] = pq[j].d;
        pq.delete(j);
      end
    end
  endtask

  always @(posedge clk) begin
    edge_n++;
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    chk("busy_a", {15'h0, busy_a}, {15'h0, clearing[0]});
    chk("state_a", {15'h0, dbg_a}, {15'h0, clearing[0]});
    chk("qvalid_a", {15'h0, qvalid_a}, {15'h0, exp_qv[0]});
    chk("qout_a", qout_a, exp_q[0]);
    chk("busy_b", {15'h0, busy_b}, {15'h0, clearing[1]});
    chk("qvalid_b", {15'h0, qvalid_b}, {15'h0, exp_qv[1]});
    chk("qout_b", qout_b, exp_q[1]);
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic acc(input logic w, input logic [3:0] a, input logic [15:0] d, input logic [1:0] b);
    req = 1'b1; wr = w; addr = a; din = d; be = b; clr = 1'b0;
    tick();
    req = 1'b0; wr = 1'b0;
  endtask

  task automatic read_all();
    for (int i = 0; i < 16; i++) acc(1'b0, 4'(i), 16'h0, 2'b00);
    tick();
    tick();
  endtask

  task automatic count_busy(input int da, input int db, input bit poke);
    int ca, cb;
    ca = int'(busy_a);
    cb = int'(busy_b);
    for (int i = 0; i < 19; i++) begin
      if (poke && i < 10) begin
        req = 1'b1;
        wr = 1'($urandom_range(0, 1));
        addr = 4'($urandom_range(0, 15));
        din = 16'($urandom_range(0, 65535));
        be = 2'b11;
      end else begin
        req = 1'b0;
      end
      tick();
      ca += int'(busy_a);
      cb += int'(busy_b);
    end
    req = 1'b0; wr = 1'b0;
    chk("busy_len_a", 16'(ca), 16'(da));
    chk("busy_len_b", 16'(cb), 16'(db));
  endtask

  initial begin
    tick(); tick(); tick();
    chk("rst_busy", {15'h0, busy_a}, 16'h1);
    chk("rst_qvalid", {15'h0, qvalid_a}, 16'h0);
    chk("rst_qout", qout_a, 16'h0);
    rst_n = 1'b1;
    count_busy(16, 12, 1'b0);

    acc(1'b0, 4'd0, 16'h0, 2'b00);
    chk("first_read_a", qout_a, 16'hA5A5);
    read_all();

    // Lane merge, and old/merged write response.
    acc(1'b1, 4'd3, 16'h1234, 2'b11);
    acc(1'b1, 4'd3, 16'hABCD, 2'b01);
    acc(1'b0, 4'd3, 16'h0, 2'b00);
    chk("merge_a", qout_a, 16'h12CD);
    tick();
    chk("merge_b", qout_b, 16'h12CD);

    acc(1'b1, 4'd5, 16'h0F0F, 2'b11);
    acc(1'b1, 4'd5, 16'hFFFF, 2'b11);
    chk("rdw_old_a", qout_a, 16'h0F0F);
    tick();
    chk("rdw_new_b", qout_b, 16'hFFFF);

    acc(1'b1, 4'd9, 16'h5566, 2'b00);
    acc(1'b1, 4'd13, 16'hBEEF, 2'b11);
    acc(1'b0, 4'd13, 16'h0, 2'b00);
    chk("oor_inrange_a", qout_a, 16'hBEEF);
    tick();
    chk("oor_qvalid_b", {15'h0, qvalid_b}, 16'h1);
    chk("oor_qout_b", qout_b, 16'h0000);
    read_all();

    // Read in flight across a clear; the same-cycle request is dropped.
    acc(1'b0, 4'd2, 16'h0, 2'b00);
    chk("pre_clr_a", qout_a, 16'hA5A5);
    req = 1'b1; wr = 1'b0; addr = 4'd4; clr = 1'b1;
    tick();
    req = 1'b0; clr = 1'b0;
    chk("inflight_qvalid_b", {15'h0, qvalid_b}, 16'h1);
    chk("inflight_qout_b", qout_b, 16'hA5A5);
    count_busy(16, 12, 1'b1);
    read_all();

    // Reset in the middle of a clear.
    acc(1'b0, 4'd3, 16'h0, 2'b00);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy_a", {15'h0, busy_a}, 16'h1);
    chk("mid_rst_qvalid_a", {15'h0, qvalid_a}, 16'h0);
    chk("mid_rst_qout_a", qout_a, 16'h0);
    chk("mid_rst_busy_b", {15'h0, busy_b}, 16'h1);
    tick(); tick();
    rst_n = 1'b1;
    count_busy(16, 12, 1'b0);
    read_all();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
